// File: rtl/mmio_uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver: status bit layout
// and the deserialiser state encoding.
package mmio_uart_rx_pkg;

  localparam int unsigned STAT_RXNE = 0;
  localparam int unsigned STAT_OVR  = 1;
  localparam int unsigned STAT_FERR = 2;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/mmio_uart_rx_fifo.sv
// Synchronous receive FIFO; a push into a full FIFO is accepted only when a
// pop frees a slot in the same cycle, otherwise it is dropped and flagged.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    overflow = push & ~do_push;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_rx.sv
// Memory-mapped 8N1 UART receiver: deserialises rx into a FIFO and answers
// core loads of the data and status registers with a one-cycle acknowledge.
module mmio_uart_rx
  import mmio_uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DATA_ADDR    = 1032,
  parameter int unsigned STAT_ADDR    = 1036
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [31:0] addr,
  input  logic        mem,
  input  logic        mem_write,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        read_ack
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_sample, fifo_push, ferr_set;

  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          read_ack_q, read_ack_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic          fifo_full, fifo_empty, fifo_ovf, fifo_pop;
  logic [7:0]    fifo_head;
  logic          hit_data, hit_stat, load_req, store_stat;
  logic [31:0]   status;
  logic          unused_wr_bits;

  assign unused_wr_bits = ^{wr_data[31:3], wr_data[0], fifo_full};

  // Two-flop synchroniser; the FSM only ever looks at rx_s_q.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // START waits half a bit so every later full-bit wait lands mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    stop_sample = (state_q == RX_STOP) && (cnt_q == LAST_CNT);
    fifo_push   = stop_sample & rx_s_q;
    ferr_set    = stop_sample & ~rx_s_q;
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      (shift_q),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  always_comb begin
    hit_data   = (addr == DATA_ADDR);
    hit_stat   = (addr == STAT_ADDR);
    load_req   = mem & ~mem_write & (hit_data | hit_stat) & ~read_ack_q;
    store_stat = mem & mem_write & hit_stat;
    fifo_pop   = load_req & hit_data & ~fifo_empty;

    status            = '0;
    status[STAT_RXNE] = ~fifo_empty;
    status[STAT_OVR]  = overrun_q;
    status[STAT_FERR] = frame_err_q;

    read_ack_d = load_req;
    rd_data_d  = '0;
    if (load_req) begin
      if (hit_data) rd_data_d = fifo_empty ? '0 : {24'b0, fifo_head};
      else          rd_data_d = status;
    end

    // Set events take priority over a coincident W1C clear.
    overrun_d   = fifo_ovf | (overrun_q & ~(store_stat & wr_data[STAT_OVR]));
    frame_err_d = ferr_set | (frame_err_q & ~(store_stat & wr_data[STAT_FERR]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      read_ack_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      read_ack_q  <= read_ack_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign read_ack = read_ack_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mmio_uart_rx.sv
// Directed bench for mmio_uart_rx with an 8-clock bit period and 4-entry FIFO.
module tb_mmio_uart_rx;

  localparam int unsigned CPB    = 8;
  localparam logic [31:0] DATA_A = 32'd1032;
  localparam logic [31:0] STAT_A = 32'd1036;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] addr = '0;
  logic        mem = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        read_ack;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .DATA_ADDR    (1032),
    .STAT_ADDR    (1036)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .addr      (addr),
    .mem       (mem),
    .mem_write (mem_write),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .read_ack  (read_ack)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_period(input logic v);
    rx = v;
    cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    bit_period(stop_v);
    rx = 1'b1;
  endtask

  task automatic bus_load(input logic [31:0] a, output logic [31:0] d, output logic ack,
                          output logic ack2, output logic [31:0] d2);
    addr = a; mem = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    mem = 1'b0;
    d = rd_data; ack = read_ack;
    @(posedge clk); #1;
    ack2 = read_ack; d2 = rd_data;
    addr = '0;
  endtask

  task automatic bus_store(input logic [31:0] a, input logic [31:0] wd, output logic ack);
    addr = a; wr_data = wd; mem = 1'b1; mem_write = 1'b1;
    @(posedge clk); #1;
    mem = 1'b0; mem_write = 1'b0;
    ack = read_ack;
    @(posedge clk); #1;
    addr = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d, d2;
    logic ack, ack2;
    cycles(3);
    n_checks++; if (read_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", read_ack); end
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", rd_data); end
    rst_n = 1'b1;
    cycles(4);
    send_frame(8'h33, 1'b1);
    cycles(2);
    rx = 1'b0;
    cycles(20);
    addr = STAT_A; mem = 1'b1;
    @(posedge clk); #1;
    mem = 1'b0;
    n_checks++; if (read_ack !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ack: got %b expected 1", read_ack); end
    n_checks++; if (rd_data !== 32'h1) begin n_fail++; $display("FAIL pre_reset_stat: got %h expected 00000001", rd_data); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (read_ack !== 1'b0) begin n_fail++; $display("FAIL midframe_reset_ack: got %b expected 0", read_ack); end
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL midframe_reset_data: got %h expected 00000000", rd_data); end
    rx = 1'b1;
    addr = '0;
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL post_reset_stat_ack: got %b expected 1", ack); end
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_stat: got %h expected 00000000", d); end
    send_frame(8'h5A, 1'b1);
    cycles(2);
    bus_load(DATA_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h5A) begin n_fail++; $display("FAIL post_reset_frame: got %h expected 0000005a", d); end
  endtask

  task automatic test_single();
    logic [31:0] d, d2;
    logic ack, ack2;
    send_frame(8'h62, 1'b1);
    cycles(1);
    bus_load(DATA_A, d, ack, ack2, d2);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b expected 1", ack); end
    n_checks++; if (d !== 32'h62) begin n_fail++; $display("FAIL single_data: got %h expected 00000062", d); end
    n_checks++; if (ack2 !== 1'b0) begin n_fail++; $display("FAIL single_ack_drop: got %b expected 0", ack2); end
    n_checks++; if (d2 !== 32'h0) begin n_fail++; $display("FAIL single_data_drop: got %h expected 00000000", d2); end
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL single_stat: got %h expected 00000000", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d, d2, exp;
    logic ack, ack2;
    for (int i = 0; i < 5; i++) send_frame(8'h41 + 8'(i), 1'b1);
    cycles(1);
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL ovr_stat: got %h expected 00000003", d); end
    for (int i = 0; i < 4; i++) begin
      exp = 32'h41 + 32'(i);
      bus_load(DATA_A, d, ack, ack2, d2);
      n_checks++; if (d !== exp) begin n_fail++; $display("FAIL ovr_pop%0d: got %h expected %h", i, d, exp); end
    end
    bus_load(DATA_A, d, ack, ack2, d2);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL empty_ack: got %b expected 1", ack); end
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL empty_data: got %h expected 00000000", d); end
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL ovr_sticky: got %h expected 00000002", d); end
    bus_store(STAT_A, 32'h2, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL store_no_ack: got %b expected 0", ack); end
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ovr_cleared: got %h expected 00000000", d); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d, d2;
    logic ack, ack2;
    send_frame(8'h55, 1'b0);
    cycles(16);
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL ferr_stat: got %h expected 00000004", d); end
    bus_store(DATA_A, 32'hFFFF_FFFF, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL data_store_no_ack: got %b expected 0", ack); end
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL ferr_after_data_store: got %h expected 00000004", d); end
    bus_store(STAT_A, 32'h4, ack);
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ferr_cleared: got %h expected 00000000", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d, d2;
    logic ack, ack2;
    rx = 1'b0;
    cycles(2);
    rx = 1'b1;
    cycles(16);
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_stat: got %h expected 00000000", d); end
    send_frame(8'h3C, 1'b1);
    cycles(1);
    bus_load(DATA_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h3C) begin n_fail++; $display("FAIL glitch_recover: got %h expected 0000003c", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, d2;
    logic [31:0] got [2];
    logic ack, ack2;
    int acks;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    cycles(1);
    got[0] = '0; got[1] = '0;
    acks = 0;
    addr = DATA_A; mem = 1'b1; mem_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (read_ack === 1'b1) begin
        if (acks < 2) got[acks] = rd_data;
        acks++;
      end
    end
    mem = 1'b0; addr = '0;
    cycles(1);
    n_checks++; if (acks !== 2) begin n_fail++; $display("FAIL held_ack_count: got %0d expected 2", acks); end
    n_checks++; if (got[0] !== 32'h11) begin n_fail++; $display("FAIL held_first: got %h expected 00000011", got[0]); end
    n_checks++; if (got[1] !== 32'h22) begin n_fail++; $display("FAIL held_second: got %h expected 00000022", got[1]); end
    bus_load(DATA_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h33) begin n_fail++; $display("FAIL held_remaining: got %h expected 00000033", d); end
    bus_load(DATA_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL held_empty: got %h expected 00000000", d); end
  endtask

  task automatic test_full_pop();
    logic [31:0] d, d2, pd, exp;
    logic ack, ack2, pa;
    for (int i = 0; i < 4; i++) send_frame(8'hA1 + 8'(i), 1'b1);
    cycles(1);
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL full_stat: got %h expected 00000001", d); end
    pa = 1'b0; pd = '0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        // stop-bit sample lands on the 79th edge after the start bit begins
        cycles(78);
        addr = DATA_A; mem = 1'b1; mem_write = 1'b0;
        @(posedge clk); #1;
        mem = 1'b0; addr = '0;
        pa = read_ack; pd = rd_data;
      end
    join
    cycles(1);
    n_checks++; if (pa !== 1'b1) begin n_fail++; $display("FAIL coinc_ack: got %b expected 1", pa); end
    n_checks++; if (pd !== 32'hA1) begin n_fail++; $display("FAIL coinc_data: got %h expected 000000a1", pd); end
    bus_load(STAT_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL coinc_no_ovr: got %h expected 00000001", d); end
    for (int i = 0; i < 4; i++) begin
      exp = 32'hA2 + 32'(i);
      bus_load(DATA_A, d, ack, ack2, d2);
      n_checks++; if (d !== exp) begin n_fail++; $display("FAIL coinc_pop%0d: got %h expected %h", i, d, exp); end
    end
    bus_load(DATA_A, d, ack, ack2, d2);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL coinc_empty: got %h expected 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_full_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
